hcsr04_echo_responder: RTL and testbench



---
 rtl/hcsr04_pkg.sv | 31 +++
 rtl/hcsr04_cycle_timer.sv | 35 +++
 rtl/hcsr04_echo_responder.sv | 168 ++++++++++++++++
 tb/tb_hcsr04_echo_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg
// Shared definitions for the HC-SR04 echo responder.
//   - state_t: responder FSM states.
//   - Protocol timing constants (microseconds and centimetres), shared with the
//     ranging controller so both sides derive cycle counts from the same numbers.
//   - max_int: helper for sizing counters from several interval lengths.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    localparam int CLK_MHZ      = 50;
    localparam int TRIG_MIN_US  = 10;     // minimum trig high width
    localparam int BURST_DLY_US = 200;    // 8 cycles of 40 kHz burst
    localparam int US_PER_CM    = 58;     // round-trip time per cm
    localparam int TIMEOUT_US   = 38000;  // echo width with no target
    localparam int HOLDOFF_US   = 10000;  // dead time after echo
    localparam int RANGE_MIN_CM = 2;
    localparam int RANGE_MAX_CM = 400;
    localparam int DIST_W       = 9;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hcsr04_cycle_timer.sv
// hcsr04_cycle_timer
// CW-bit down-counter used for the burst, echo and holdoff intervals.
// Loading N makes done assert on the N-th cycle after the load, so a state that
// leaves on done stays exactly N cycles.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-low reset
//   load     - load load_val into the counter
//   load_val - interval length in cycles
//   done     - high while the count is 1 (last cycle of the interval)
module hcsr04_cycle_timer #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == CW'(1));

endmodule

// File: rtl/hcsr04_echo_responder.sv
// hcsr04_echo_responder
// Sensor-side model of the HC-SR04 trig/echo protocol. Validates the trig
// width, waits the burst delay, then returns an echo pulse whose width encodes
// the distance latched at trig fall, followed by a holdoff dead time.
// Ports:
//   clk         - system clock
//   reset       - asynchronous active-low reset
//   trig        - trigger from the ranging controller (synchronous to clk)
//   dist_cm     - programmed distance in cm, sampled at an accepted trig fall
//   obj_present - 0 = no target, sampled at an accepted trig fall
//   echo        - echo pulse back to the controller
//   busy        - high from accepted trig fall until holdoff ends
//   trig_err    - one-cycle pulse for a short trig or a trig while busy
module hcsr04_echo_responder
    import hcsr04_pkg::*;
#(
    parameter int TRIG_MIN_CYC  = TRIG_MIN_US * CLK_MHZ,
    parameter int BURST_DLY_CYC = BURST_DLY_US * CLK_MHZ,
    parameter int CYC_PER_CM    = US_PER_CM * CLK_MHZ,
    parameter int MIN_CM        = RANGE_MIN_CM,
    parameter int MAX_CM        = RANGE_MAX_CM,
    parameter int TIMEOUT_CYC   = TIMEOUT_US * CLK_MHZ,
    parameter int HOLDOFF_CYC   = HOLDOFF_US * CLK_MHZ
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic [DIST_W-1:0] dist_cm,
    input  logic              obj_present,
    output logic              echo,
    output logic              busy,
    output logic              trig_err
);

    localparam int WW = $clog2(TRIG_MIN_CYC + 1);
    localparam int CW = $clog2(max_int(max_int(TIMEOUT_CYC, MAX_CM * CYC_PER_CM),
                                       max_int(HOLDOFF_CYC, BURST_DLY_CYC)) + 1);

    localparam logic [WW-1:0]     TRIG_MIN_W = WW'(TRIG_MIN_CYC);
    localparam logic [CW-1:0]     BURST_W    = CW'(BURST_DLY_CYC);
    localparam logic [CW-1:0]     CYC_W      = CW'(CYC_PER_CM);
    localparam logic [CW-1:0]     TIMEOUT_W  = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0]     HOLDOFF_W  = CW'(HOLDOFF_CYC);
    localparam logic [DIST_W-1:0] DIST_MIN   = DIST_W'(MIN_CM);
    localparam logic [DIST_W-1:0] DIST_MAX   = DIST_W'(MAX_CM);

    state_t            state, state_next;
    logic              trig_q;
    logic              rise, fall;
    logic [WW-1:0]     width, width_next, width_plus;
    logic [DIST_W-1:0] eff_cm, eff_cm_next;
    logic              no_target, no_target_next;
    logic [CW-1:0]     echo_width;
    logic              err_next;
    logic              tmr_load;
    logic [CW-1:0]     tmr_val;
    logic              tmr_done;

    assign rise = trig & ~trig_q;
    assign fall = ~trig & trig_q;

    // Includes the current high cycle, so width_plus on the fall cycle equals
    // the number of cycles trig was sampled high.
    assign width_plus = (width == TRIG_MIN_W) ? width : width + 1'b1;

    assign echo_width = no_target ? TIMEOUT_W : CW'(eff_cm) * CYC_W;

    hcsr04_cycle_timer #(
        .CW(CW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_next     = state;
        width_next     = width;
        eff_cm_next    = eff_cm;
        no_target_next = no_target;
        err_next       = 1'b0;
        tmr_load       = 1'b0;
        tmr_val        = '0;

        case (state)
            IDLE: begin
                if (rise) begin
                    width_next = '0;
                    state_next = TRIG_HI;
                end
            end

            TRIG_HI: begin
                if (fall) begin
                    if (width_plus >= TRIG_MIN_W) begin
                        no_target_next = ~obj_present || (dist_cm > DIST_MAX);
                        eff_cm_next    = (dist_cm < DIST_MIN) ? DIST_MIN : dist_cm;
                        tmr_load       = 1'b1;
                        tmr_val        = BURST_W;
                        state_next     = BURST;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end else if (trig) begin
                    width_next = width_plus;
                end
            end

            BURST: begin
                err_next = rise;
                if (tmr_done) begin
                    tmr_load   = 1'b1;
                    tmr_val    = echo_width;
                    state_next = ECHO;
                end
            end

            ECHO: begin
                err_next = rise;
                if (tmr_done) begin
                    tmr_load   = 1'b1;
                    tmr_val    = HOLDOFF_W;
                    state_next = HOLDOFF;
                end
            end

            HOLDOFF: begin
                // A rise on the expiry cycle is still rejected; the trig must
                // rise again once the responder is idle.
                err_next = rise;
                if (tmr_done) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the current state, which places echo rise
    // BURST_DLY_CYC+1 cycles after the trig-low sample and keeps echo high
    // exactly for the timer interval.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            trig_q    <= 1'b0;
            width     <= '0;
            eff_cm    <= '0;
            no_target <= 1'b0;
            echo      <= 1'b0;
            busy      <= 1'b0;
            trig_err  <= 1'b0;
        end else begin
            state     <= state_next;
            trig_q    <= trig;
            width     <= width_next;
            eff_cm    <= eff_cm_next;
            no_target <= no_target_next;
            echo      <= (state == ECHO);
            busy      <= (state == BURST) || (state == ECHO) || (state == HOLDOFF);
            trig_err  <= err_next;
        end
    end

endmodule

// File: tb/tb_hcsr04_echo_responder.sv
// tb_hcsr04_echo_responder
// Directed bench for hcsr04_echo_responder with small timing parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_hcsr04_echo_responder;

    logic       clk;
    logic       reset;
    logic       trig;
    logic [8:0] dist_cm;
    logic       obj_present;
    logic       echo;
    logic       busy;
    logic       trig_err;

    int checks = 0;
    int passes = 0;

    hcsr04_echo_responder #(
        .TRIG_MIN_CYC  (5),
        .BURST_DLY_CYC (10),
        .CYC_PER_CM    (4),
        .MIN_CM        (2),
        .MAX_CM        (400),
        .TIMEOUT_CYC   (2000),
        .HOLDOFF_CYC   (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trig        (trig),
        .dist_cm     (dist_cm),
        .obj_present (obj_present),
        .echo        (echo),
        .busy        (busy),
        .trig_err    (trig_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive trig high for 'hold' sampled cycles, starting from a falling edge.
    task automatic drive_trig(input int hold);
        trig = 1'b1;
        repeat (hold) @(negedge clk);
        trig = 1'b0;
    endtask

    // Issue a trig and observe one transaction. n counts falling edges after
    // trig was lowered; n=1 follows the edge that first samples trig low.
    // Optional 2-cycle trig pulses start at falling edges inj_a / inj_b, and
    // dist_cm is rewritten at falling edge chg_at.
    task automatic run_meas(input int hold, input int inj_a, input int inj_b,
                            input int chg_at, input logic [8:0] chg_val,
                            input int limit,
                            output int lat, output int width, output int tail,
                            output int errs, output logic busy2, output logic busy_any);
        int   n;
        int   fall_n;
        logic fin;
        lat = -1; width = 0; tail = -1; errs = 0; busy2 = 1'b0; busy_any = 1'b0;
        fall_n = -1; fin = 1'b0; n = 0;
        drive_trig(hold);
        while (!fin && n < limit) begin
            @(negedge clk);
            n++;
            if (trig_err) errs++;
            if (n == 2) busy2 = busy;
            if (busy) busy_any = 1'b1;
            if (echo) begin
                if (lat < 0) lat = n - 1;
                width++;
            end
            if (lat >= 0 && !echo && fall_n < 0) fall_n = n;
            trig = (inj_a > 0 && n >= inj_a && n < inj_a + 2) ||
                   (inj_b > 0 && n >= inj_b && n < inj_b + 2);
            if (n == chg_at) dist_cm = chg_val;
            if (fall_n >= 0 && !busy) begin
                tail = n - fall_n;
                fin  = 1'b1;
            end
        end
        trig = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; trig = 1'b0; dist_cm = 9'd25; obj_present = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (echo !== 1'b0) $display("FAIL reset_echo: got %b expected 0", echo); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (trig_err !== 1'b0) $display("FAIL reset_trig_err: got %b expected 0", trig_err); else passes++;
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_normal();
        int lat, width, tail, errs; logic b2, ba;
        dist_cm = 9'd25; obj_present = 1'b1;
        run_meas(6, 0, 0, 0, 9'd0, 300, lat, width, tail, errs, b2, ba);
        checks++; if (lat !== 11) $display("FAIL normal_latency: got %0d expected 11", lat); else passes++;
        checks++; if (width !== 100) $display("FAIL normal_width: got %0d expected 100", width); else passes++;
        checks++; if (tail !== 20) $display("FAIL normal_holdoff: got %0d expected 20", tail); else passes++;
        checks++; if (errs !== 0) $display("FAIL normal_trig_err: got %0d pulses expected 0", errs); else passes++;
        checks++; if (b2 !== 1'b1) $display("FAIL normal_busy_rise: got %b expected 1", b2); else passes++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_short_trig();
        int lat, width, tail, errs; logic b2, ba;
        dist_cm = 9'd25; obj_present = 1'b1;
        run_meas(3, 0, 0, 0, 9'd0, 40, lat, width, tail, errs, b2, ba);
        checks++; if (errs !== 1) $display("FAIL short_trig_err: got %0d pulses expected 1", errs); else passes++;
        checks++; if (width !== 0) $display("FAIL short_no_echo: got %0d echo cycles expected 0", width); else passes++;
        checks++; if (ba !== 1'b0) $display("FAIL short_no_busy: got %b expected 0", ba); else passes++;
        run_meas(5, 0, 0, 0, 9'd0, 300, lat, width, tail, errs, b2, ba);
        checks++; if (lat !== 11) $display("FAIL min_trig_latency: got %0d expected 11", lat); else passes++;
        checks++; if (width !== 100) $display("FAIL min_trig_width: got %0d expected 100", width); else passes++;
        checks++; if (errs !== 0) $display("FAIL min_trig_err: got %0d pulses expected 0", errs); else passes++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_range();
        int lat, width, tail, errs; logic b2, ba;
        dist_cm = 9'd25; obj_present = 1'b0;
        run_meas(6, 0, 0, 0, 9'd0, 2200, lat, width, tail, errs, b2, ba);
        checks++; if (width !== 2000) $display("FAIL no_object_width: got %0d expected 2000", width); else passes++;
        checks++; if (lat !== 11) $display("FAIL no_object_latency: got %0d expected 11", lat); else passes++;
        repeat (3) @(negedge clk);
        dist_cm = 9'd450; obj_present = 1'b1;
        run_meas(6, 0, 0, 0, 9'd0, 2200, lat, width, tail, errs, b2, ba);
        checks++; if (width !== 2000) $display("FAIL over_range_width: got %0d expected 2000", width); else passes++;
        repeat (3) @(negedge clk);
        dist_cm = 9'd0;
        run_meas(6, 0, 0, 0, 9'd0, 300, lat, width, tail, errs, b2, ba);
        checks++; if (width !== 8) $display("FAIL zero_cm_width: got %0d expected 8", width); else passes++;
        repeat (3) @(negedge clk);
        dist_cm = 9'd3;
        run_meas(6, 0, 0, 0, 9'd0, 300, lat, width, tail, errs, b2, ba);
        checks++; if (width !== 12) $display("FAIL three_cm_width: got %0d expected 12", width); else passes++;
        repeat (3) @(negedge clk);
        dist_cm = 9'd400;
        run_meas(6, 0, 0, 0, 9'd0, 1800, lat, width, tail, errs, b2, ba);
        checks++; if (width !== 1600) $display("FAIL max_cm_width: got %0d expected 1600", width); else passes++;
        repeat (3) @(negedge clk);
        dist_cm = 9'd25;
    endtask

    task automatic test_back_to_back();
        int lat, width, tail, errs; logic b2, ba;
        int echo_cnt;
        dist_cm = 9'd25; obj_present = 1'b1;
        // echo is high over n=12..111, holdoff covers n=112..131
        run_meas(6, 50, 120, 0, 9'd0, 300, lat, width, tail, errs, b2, ba);
        checks++; if (errs !== 2) $display("FAIL busy_trig_err: got %0d pulses expected 2", errs); else passes++;
        checks++; if (lat !== 11) $display("FAIL busy_trig_latency: got %0d expected 11", lat); else passes++;
        checks++; if (width !== 100) $display("FAIL busy_trig_width: got %0d expected 100", width); else passes++;
        checks++; if (tail !== 20) $display("FAIL busy_trig_holdoff: got %0d expected 20", tail); else passes++;
        echo_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (echo || busy) echo_cnt++;
        end
        checks++; if (echo_cnt !== 0) $display("FAIL busy_trig_no_second_echo: got %0d active cycles expected 0", echo_cnt); else passes++;
        run_meas(6, 0, 0, 0, 9'd0, 300, lat, width, tail, errs, b2, ba);
        checks++; if (width !== 100) $display("FAIL after_idle_width: got %0d expected 100", width); else passes++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_holdoff_collision();
        int lat, width, tail, errs; logic b2, ba;
        int act_cnt;
        dist_cm = 9'd25; obj_present = 1'b1;
        // Rise sampled on the last holdoff cycle (busy drops at n=132).
        run_meas(6, 130, 0, 0, 9'd0, 300, lat, width, tail, errs, b2, ba);
        checks++; if (errs !== 1) $display("FAIL collision_trig_err: got %0d pulses expected 1", errs); else passes++;
        checks++; if (tail !== 20) $display("FAIL collision_holdoff: got %0d expected 20", tail); else passes++;
        act_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (echo || busy) act_cnt++;
        end
        checks++; if (act_cnt !== 0) $display("FAIL collision_ignored: got %0d active cycles expected 0", act_cnt); else passes++;
    endtask

    task automatic test_dist_change();
        int lat, width, tail, errs; logic b2, ba;
        dist_cm = 9'd25; obj_present = 1'b1;
        run_meas(6, 0, 0, 1, 9'd100, 300, lat, width, tail, errs, b2, ba);
        checks++; if (width !== 100) $display("FAIL dist_change_width: got %0d expected 100", width); else passes++;
        repeat (3) @(negedge clk);
        dist_cm = 9'd25;
    endtask

    task automatic test_reset_mid_echo();
        int lat, width, tail, errs; logic b2, ba;
        dist_cm = 9'd25; obj_present = 1'b1;
        drive_trig(6);
        repeat (50) @(negedge clk);
        checks++; if (echo !== 1'b1) $display("FAIL mid_echo_before_reset: got %b expected 1", echo); else passes++;
        #2 reset = 1'b0;
        #1;
        checks++; if (echo !== 1'b0) $display("FAIL async_reset_echo: got %b expected 0", echo); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL async_reset_busy: got %b expected 0", busy); else passes++;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        run_meas(6, 0, 0, 0, 9'd0, 300, lat, width, tail, errs, b2, ba);
        checks++; if (lat !== 11) $display("FAIL post_reset_latency: got %0d expected 11", lat); else passes++;
        checks++; if (width !== 100) $display("FAIL post_reset_width: got %0d expected 100", width); else passes++;
        checks++; if (tail !== 20) $display("FAIL post_reset_holdoff: got %0d expected 20", tail); else passes++;
    endtask

    initial begin
        reset = 1'b0; trig = 1'b0; dist_cm = 9'd25; obj_present = 1'b1;
        @(negedge clk);
        test_reset();
        test_normal();
        test_short_trig();
        test_range();
        test_back_to_back();
        test_holdoff_collision();
        test_dist_change();
        test_reset_mid_echo();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
